// File: rtl/mesi_isc_breq_arb.sv
// Round-robin arbiter feeding coherence broadcast requests from four
// CPU queues into the broadcast FIFO, tagging each with a rolling ID.
module mesi_isc_breq_arb #(
    parameter int ADDR_WIDTH       = 32,
    parameter int BROAD_TYPE_WIDTH = 2,
    parameter int BROAD_ID_WIDTH   = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    breq_valid_array_i,
    input  logic [4*BROAD_TYPE_WIDTH-1:0] breq_type_array_i,
    input  logic [4*ADDR_WIDTH-1:0]       breq_addr_array_i,
    input  logic                          fifo_status_full_i,
    output logic [3:0]                    breq_ack_array_o,
    output logic                          broad_fifo_wr_o,
    output logic [ADDR_WIDTH-1:0]         broad_addr_o,
    output logic [BROAD_TYPE_WIDTH-1:0]   broad_type_o,
    output logic [1:0]                    broad_cpu_id_o,
    output logic [BROAD_ID_WIDTH-1:0]     broad_id_o
);

    localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_NOP = BROAD_TYPE_WIDTH'(0);
    localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_RSV = BROAD_TYPE_WIDTH'(3);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t                      state;
    state_t                      state_nx;
    logic [1:0]                  last_grant;
    logic [BROAD_ID_WIDTH-1:0]   id_cnt;
    logic [3:0]                  elig;
    logic [1:0]                  win;
    logic [1:0]                  idx;
    logic                        found;
    logic                        issue;
    logic [BROAD_TYPE_WIDTH-1:0] cpu_type [4];

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            cpu_type[n] = breq_type_array_i[n*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH];
            elig[n]     = breq_valid_array_i[n]
                          && (cpu_type[n] != TYPE_NOP)
                          && (cpu_type[n] != TYPE_RSV);
        end
    end

    // Scan starts one past the previous winner so every CPU gets a turn.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = last_grant + 2'(i + 1);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        unique case (state)
            IDLE: begin
                if (found && !fifo_status_full_i) begin
                    issue    = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            last_grant       <= 2'd3;
            id_cnt           <= '0;
            broad_fifo_wr_o  <= 1'b0;
            breq_ack_array_o <= '0;
            broad_addr_o     <= '0;
            broad_type_o     <= '0;
            broad_cpu_id_o   <= '0;
            broad_id_o       <= '0;
        end else begin
            state            <= state_nx;
            broad_fifo_wr_o  <= issue;
            breq_ack_array_o <= issue ? (4'b0001 << win) : 4'b0000;
            if (issue) begin
                broad_addr_o   <= breq_addr_array_i[win*ADDR_WIDTH +: ADDR_WIDTH];
                broad_type_o   <= cpu_type[win];
                broad_cpu_id_o <= win;
                broad_id_o     <= id_cnt;
                last_grant     <= win;
                id_cnt         <= id_cnt + BROAD_ID_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_mesi_isc_breq_arb.sv
// Scoreboard bench for mesi_isc_breq_arb: expected writes are queued
// as requests are posted and matched against each FIFO write.
module tb_mesi_isc_breq_arb;

    typedef struct packed {
        logic [1:0]  cpu;
        logic [4:0]  id;
        logic [1:0]  typ;
        logic [31:0] addr;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   valid;
    logic [7:0]   type_bus;
    logic [127:0] addr_bus;
    logic         full = 1'b0;
    logic [3:0]   ack;
    logic         wr;
    logic [31:0]  b_addr;
    logic [1:0]   b_type;
    logic [1:0]   b_cpu;
    logic [4:0]   b_id;

    int          rem [4];
    logic [1:0]  typ [4];
    logic [31:0] adr [4];
    exp_t        sb [$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          first_wr = 0;
    int          last_wr = 0;

    assign valid    = {rem[3] != 0, rem[2] != 0, rem[1] != 0, rem[0] != 0};
    assign type_bus = {typ[3], typ[2], typ[1], typ[0]};
    assign addr_bus = {adr[3], adr[2], adr[1], adr[0]};

    mesi_isc_breq_arb dut (
        .clk                (clk),
        .rst                (rst),
        .breq_valid_array_i (valid),
        .breq_type_array_i  (type_bus),
        .breq_addr_array_i  (addr_bus),
        .fifo_status_full_i (full),
        .breq_ack_array_o   (ack),
        .broad_fifo_wr_o    (wr),
        .broad_addr_o       (b_addr),
        .broad_type_o       (b_type),
        .broad_cpu_id_o     (b_cpu),
        .broad_id_o         (b_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int cpu, input int id, input int t,
                        input logic [31:0] a);
        exp_t e;
        e.cpu  = 2'(cpu);
        e.id   = 5'(id);
        e.typ  = 2'(t);
        e.addr = a;
        sb.push_back(e);
    endtask

    // Requester model: a queue pops one entry per ack pulse.
    initial begin
        forever begin
            @(negedge clk);
            for (int n = 0; n < 4; n++)
                if (ack[n] && rem[n] > 0) rem[n]--;
        end
    end

    // Write monitor / scoreboard checker
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            if (rst && ack != 4'b0000 && !wr)
                chk("ack_without_wr", {60'd0, ack}, 64'd0);
            if (rst && wr) begin
                wr_cnt++;
                if (wr_cnt == 1) first_wr = cyc;
                last_wr = cyc;
                got = {b_cpu, b_id, b_type, b_addr};
                if (sb.size() == 0) begin
                    chk("unexpected_wr", {23'd0, got}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("wr_data", {23'd0, got}, {23'd0, e});
                    chk("wr_ack", {60'd0, ack}, {60'd0, 4'b0001 << e.cpu});
                end
            end
        end
    end

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk(tag, 64'(sb.size()), 64'd0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        for (int n = 0; n < 4; n++) begin
            rem[n] = 0;
            typ[n] = 2'd0;
            adr[n] = 32'h0;
        end
        repeat (2) @(negedge clk);
        chk("rst_wr", {63'd0, wr}, 64'd0);
        chk("rst_outs", {b_addr, b_type, b_cpu, b_id, ack},
            64'd0);
        rst = 1'b1;
        @(negedge clk);

        // single request, latency 1
        typ[2] = 2'd2;
        adr[2] = 32'h1000;
        push(2, 0, 2, 32'h1000);
        rem[2] = 1;
        @(negedge clk);
        chk("t1_wr_lat", {63'd0, wr}, 64'd1);
        @(negedge clk);
        chk("t1_wr_drop", {63'd0, wr}, 64'd0);
        wait_drain("t1_drain", 10);

        // all four held: round-robin from CPU0
        do_reset();
        wr_cnt = 0;
        for (int n = 0; n < 4; n++) begin
            typ[n] = 2'd1;
            adr[n] = 32'h100 * (n + 1);
        end
        push(0, 0, 1, 32'h100);
        push(1, 1, 1, 32'h200);
        push(2, 2, 1, 32'h300);
        push(3, 3, 1, 32'h400);
        push(0, 4, 1, 32'h100);
        rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
        wait_drain("t2_drain", 30);
        chk("t2_count", 64'(wr_cnt), 64'd5);
        chk("t2_spacing", 64'(last_wr - first_wr), 64'd8);

        // full stalls issue
        full = 1'b1;
        typ[1] = 2'd2; adr[1] = 32'hA1;
        typ[3] = 2'd2; adr[3] = 32'hA3;
        rem[1] = 1; rem[3] = 1;
        wr_cnt = 0;
        repeat (5) @(negedge clk);
        chk("t3_stall_wr", 64'(wr_cnt), 64'd0);
        chk("t3_stall_rem", 64'(rem[1] + rem[3]), 64'd2);
        push(1, 5, 2, 32'hA1);
        push(3, 6, 2, 32'hA3);
        full = 1'b0;
        @(negedge clk);
        chk("t3_wr1", {63'd0, wr}, 64'd1);
        @(negedge clk);
        chk("t3_idle", {63'd0, wr}, 64'd0);
        @(negedge clk);
        chk("t3_wr2", {63'd0, wr}, 64'd1);
        wait_drain("t3_drain", 10);

        // id wrap over 33 requests
        do_reset();
        typ[0] = 2'd2;
        adr[0] = 32'hBEEF;
        for (int i = 0; i < 32; i++) push(0, i, 2, 32'hBEEF);
        push(0, 0, 2, 32'hBEEF);
        rem[0] = 33;
        wait_drain("t4_drain", 100);
        chk("t4_rem", 64'(rem[0]), 64'd0);

        // NOP request never acked
        typ[0] = 2'd0; adr[0] = 32'h55;
        typ[3] = 2'd2; adr[3] = 32'h77;
        push(3, 1, 2, 32'h77);
        rem[0] = 1; rem[3] = 1;
        wait_drain("t5_drain", 10);
        repeat (8) @(negedge clk);
        chk("t5_nop_pending", 64'(rem[0]), 64'd1);
        rem[0] = 0;

        // reset during ISSUE
        typ[1] = 2'd1; adr[1] = 32'hC1;
        push(1, 2, 1, 32'hC1);
        rem[1] = 1;
        @(negedge clk);
        chk("t6_wr_before", {63'd0, wr}, 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("t6_wr_async", {63'd0, wr}, 64'd0);
        chk("t6_ack_async", {60'd0, ack}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_drain("t6_drain_a", 5);
        typ[0] = 2'd1; adr[0] = 32'hD0;
        typ[2] = 2'd2; adr[2] = 32'hD2;
        push(0, 0, 1, 32'hD0);
        push(2, 1, 2, 32'hD2);
        rem[0] = 1; rem[2] = 1;
        wait_drain("t6_drain_b", 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mesi_isc_breq_arb.md
Name: mesi_isc_breq_arb

Overview:
- Upstream feeder of the broadcast stage (`mesi_isc_broad`).
- Takes coherence broadcast requests from four per-CPU request queues and picks one per issue slot using round-robin.
- Tags each accepted request with a rolling broadcast ID and writes it into the broadcast FIFO through a registered write port.
- Throttles issue against the broadcast FIFO's full flag, so no write is ever lost.

Parameters:
- ADDR_WIDTH, 32, width of a broadcast address.
- BROAD_TYPE_WIDTH, 2, width of a broadcast type. Encoding: 0 = NOP, 1 = WR, 2 = RD, 3 = reserved.
- BROAD_ID_WIDTH, 5, width of the broadcast ID counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low (asserted at 0)
- breq_valid_array_i  in  4  per-CPU request pending; bit n belongs to CPU n
- breq_type_array_i  in  4*BROAD_TYPE_WIDTH  per-CPU type; CPU n occupies slice [n*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH]
- breq_addr_array_i  in  4*ADDR_WIDTH  per-CPU address; CPU n occupies slice [n*ADDR_WIDTH +: ADDR_WIDTH]
- fifo_status_full_i  in  1  broadcast FIFO full
- breq_ack_array_o  out  4  one-hot, 1-cycle pop pulse to the winning CPU's queue
- broad_fifo_wr_o  out  1  broadcast FIFO write strobe
- broad_addr_o  out  ADDR_WIDTH  address of the issued request
- broad_type_o  out  BROAD_TYPE_WIDTH  type of the issued request
- broad_cpu_id_o  out  2  initiating CPU
- broad_id_o  out  BROAD_ID_WIDTH  broadcast ID of the issued request

Behaviour:
- Reset (rst=0, asynchronous):
  - all outputs 0;
  - state = IDLE;
  - id_cnt = 0;
  - last_grant = 3, so CPU0 has first priority.
- Eligible CPU n: valid[n]=1 and type[n] is neither NOP nor 3. Ineligible requests are never acked and never written.
- Arbitration: scan CPUs starting at last_grant+1 (mod 4); the first eligible CPU wins.
- FSM with two states, IDLE and ISSUE:
  - IDLE → ISSUE when any CPU is eligible and fifo_status_full_i=0, both sampled in the same cycle. On that edge:
    - register winner's addr, type, cpu_id and id_cnt into the outputs;
    - set broad_fifo_wr_o=1 and breq_ack_array_o[winner]=1;
    - last_grant ← winner;
    - id_cnt ← id_cnt+1, wrapping modulo 2^BROAD_ID_WIDTH (31→0 at default width).
  - ISSUE → IDLE unconditionally on the next edge. Clear broad_fifo_wr_o and breq_ack_array_o; data outputs hold their last values.
- Throughput and latency:
  - at most one issue every 2 cycles;
  - latency is 1 cycle from an eligible sample to write/ack.
- The idle cycle after each write lets fifo_status_full_i reflect that write before the next decision, so a FIFO that goes full on the last slot is never overwritten.
- fifo_status_full_i=1 in IDLE: no issue, no ack. Priority and id_cnt are unchanged, and requests wait indefinitely.
- Requester contract: valid, type and addr must stay stable until acked. The ack pulse and the write strobe occur in the same cycle.
- Inputs sampled while in ISSUE are ignored.
- Reset asserted mid-ISSUE clears the write strobe immediately. The request being written at that moment is considered dropped.
- breq_ack_array_o is always one-hot or zero; it is nonzero only while broad_fifo_wr_o=1.

Test Plan:
- Reset, then CPU2 valid with type=2 and addr=0x1000 → one cycle later: wr=1, ack=4'b0100, cpu_id=2, id=0, type=2, addr=0x1000. Next cycle wr=0.
- All four CPUs valid and held (re-asserted after each ack, type=1) → writes on alternate cycles in cpu_id order 0,1,2,3,0, with ids 0,1,2,3,4.
- CPU1 and CPU3 valid, fifo_status_full_i=1 for 5 cycles → no wr, no ack, id unchanged. Full drops → CPU1 issues next cycle, then CPU3 after the idle slot.
- Issue 32 requests → ids run 0..31, and the 33rd request carries id=0.
- CPU0 valid with type=0 (NOP) plus CPU3 type=2 → only CPU3 is acked. CPU0 is never acked while it stays NOP.
- Assert rst during the ISSUE cycle → wr and ack drop to 0 asynchronously. After release, next grant goes to CPU0 with id=0.
